// File: rtl/nes_video_timing_gen_if.sv
// Signal bundle between the raster timing generator and its PPU/display consumers.
// The generator side uses the master modport; test_pattern_in exists only with NES_VIDEO_TEST_PATTERN_EN.
interface nes_video_timing_gen_if;
    logic       en;
    logic [5:0] sys_palette_idx_in;
`ifdef NES_VIDEO_TEST_PATTERN_EN
    logic       test_pattern_in;
`endif
    logic       hsync;
    logic       vsync;
    logic [2:0] r_out;
    logic [2:0] g_out;
    logic [1:0] b_out;
    logic [9:0] nes_x_out;
    logic [9:0] nes_y_out;
    logic [9:0] nes_y_next_out;
    logic       pix_pulse_out;
    logic       vblank_out;
    logic       frame_start_out;

`ifdef NES_VIDEO_TEST_PATTERN_EN
    modport master (
        input  en, sys_palette_idx_in, test_pattern_in,
        output hsync, vsync, r_out, g_out, b_out,
        output nes_x_out, nes_y_out, nes_y_next_out,
        output pix_pulse_out, vblank_out, frame_start_out
    );
    modport slave (
        output en, sys_palette_idx_in, test_pattern_in,
        input  hsync, vsync, r_out, g_out, b_out,
        input  nes_x_out, nes_y_out, nes_y_next_out,
        input  pix_pulse_out, vblank_out, frame_start_out
    );
`else
    modport master (
        input  en, sys_palette_idx_in,
        output hsync, vsync, r_out, g_out, b_out,
        output nes_x_out, nes_y_out, nes_y_next_out,
        output pix_pulse_out, vblank_out, frame_start_out
    );
    modport slave (
        output en, sys_palette_idx_in,
        input  hsync, vsync, r_out, g_out, b_out,
        input  nes_x_out, nes_y_out, nes_y_next_out,
        input  pix_pulse_out, vblank_out, frame_start_out
    );
`endif
endinterface

// File: rtl/nes_video_timing_gen.sv
// NES PPU raster timing generator: pixel divider, h/v counters, registered sync and RGB332 palette output.
// Optional NES_VIDEO_TEST_PATTERN_EN adds test_pattern_in, which replaces the palette index with colour bars.
module nes_video_timing_gen #(
    parameter int H_ACTIVE = 256,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 15,
    parameter int PIX_DIV  = 4,
    parameter int SYNC_POL = 0
) (
    input logic                    clk,
    input logic                    rst,
    nes_video_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [3:0]  DIV_LAST = 4'(PIX_DIV - 1);
    // Window bounds are 11 bits so an end bound of exactly 1024 still compares correctly.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ON   = (SYNC_POL != 0);

    logic [3:0] div_cnt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [7:0] rgb_q;
    logic       hsync_q;
    logic       vsync_q;

    logic        pix_pulse;
    logic        h_last;
    logic        v_last;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        active;
    logic        hs_act;
    logic        vs_act;
    logic [5:0]  pal_idx;
    logic [7:0]  pal_rgb;

    function automatic logic [7:0] nes_lut(input logic [5:0] idx);
        logic [7:0] c;
        case (idx)
            6'h00: c = {3'd3, 3'd3, 2'd1};
            6'h01: c = {3'd0, 3'd0, 2'd2};
            6'h02: c = {3'd0, 3'd0, 2'd2};
            6'h03: c = {3'd2, 3'd0, 2'd2};
            6'h04: c = {3'd4, 3'd0, 2'd1};
            6'h05: c = {3'd5, 3'd0, 2'd0};
            6'h06: c = {3'd5, 3'd0, 2'd0};
            6'h07: c = {3'd3, 3'd1, 2'd0};
            6'h08: c = {3'd2, 3'd2, 2'd0};
            6'h09: c = {3'd0, 3'd3, 2'd0};
            6'h0A: c = {3'd0, 3'd3, 2'd0};
            6'h0B: c = {3'd0, 3'd3, 2'd0};
            6'h0C: c = {3'd0, 3'd2, 2'd1};
            6'h10: c = {3'd5, 3'd5, 2'd2};
            6'h11: c = {3'd0, 3'd3, 2'd3};
            6'h12: c = {3'd1, 3'd2, 2'd3};
            6'h13: c = {3'd4, 3'd1, 2'd3};
            6'h14: c = {3'd6, 3'd0, 2'd2};
            6'h15: c = {3'd7, 3'd0, 2'd1};
            6'h16: c = {3'd6, 3'd1, 2'd0};
            6'h17: c = {3'd5, 3'd2, 2'd0};
            6'h18: c = {3'd4, 3'd3, 2'd0};
            6'h19: c = {3'd0, 3'd5, 2'd0};
            6'h1A: c = {3'd0, 3'd5, 2'd0};
            6'h1B: c = {3'd0, 3'd5, 2'd1};
            6'h1C: c = {3'd0, 3'd4, 2'd2};
            6'h20: c = {3'd7, 3'd7, 2'd3};
            6'h21: c = {3'd2, 3'd5, 2'd3};
            6'h22: c = {3'd4, 3'd4, 2'd3};
            6'h23: c = {3'd6, 3'd3, 2'd3};
            6'h24: c = {3'd7, 3'd3, 2'd3};
            6'h25: c = {3'd7, 3'd3, 2'd2};
            6'h26: c = {3'd7, 3'd4, 2'd1};
            6'h27: c = {3'd7, 3'd5, 2'd0};
            6'h28: c = {3'd6, 3'd6, 2'd0};
            6'h29: c = {3'd4, 3'd7, 2'd0};
            6'h2A: c = {3'd2, 3'd7, 2'd1};
            6'h2B: c = {3'd2, 3'd7, 2'd2};
            6'h2C: c = {3'd0, 3'd7, 2'd3};
            6'h30: c = {3'd7, 3'd7, 2'd3};
            6'h31: c = {3'd5, 3'd6, 2'd3};
            6'h32: c = {3'd6, 3'd6, 2'd3};
            6'h33: c = {3'd7, 3'd6, 2'd3};
            6'h34: c = {3'd7, 3'd5, 2'd3};
            6'h35: c = {3'd7, 3'd6, 2'd3};
            6'h36: c = {3'd7, 3'd6, 2'd2};
            6'h37: c = {3'd7, 3'd7, 2'd2};
            6'h38: c = {3'd7, 3'd7, 2'd1};
            6'h39: c = {3'd6, 3'd7, 2'd1};
            6'h3A: c = {3'd5, 3'd7, 2'd2};
            6'h3B: c = {3'd5, 3'd7, 2'd3};
            6'h3C: c = {3'd5, 3'd7, 2'd3};
            // x0D..x0F of every row are the black/reserved entries
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign pix_pulse = vid.en && (div_cnt == DIV_LAST);
    assign h_last    = (h_cnt == H_LAST);
    assign v_last    = (v_cnt == V_LAST);
    assign h_ext     = {1'b0, h_cnt};
    assign v_ext     = {1'b0, v_cnt};

    assign active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign hs_act = (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign vs_act = (v_ext >= VS_BEG) && (v_ext < VS_END);

`ifdef NES_VIDEO_TEST_PATTERN_EN
    // 32-pixel-wide bars walking the 0x10..0x17 palette row
    assign pal_idx = vid.test_pattern_in ? {3'b010, h_cnt[7:5]} : vid.sys_palette_idx_in;
`else
    assign pal_idx = vid.sys_palette_idx_in;
`endif
    assign pal_rgb = nes_lut(pal_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            rgb_q   <= '0;
            hsync_q <= ~SYNC_ON;
            vsync_q <= ~SYNC_ON;
        end else if (pix_pulse) begin
            div_cnt <= '0;
            h_cnt   <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last)
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            // Outputs sample the slot just finishing, so colour and sync lag the counters by one pixel together.
            rgb_q   <= active ? pal_rgb : 8'h00;
            hsync_q <= hs_act ? SYNC_ON : ~SYNC_ON;
            vsync_q <= vs_act ? SYNC_ON : ~SYNC_ON;
        end else if (vid.en) begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    assign vid.hsync           = hsync_q;
    assign vid.vsync           = vsync_q;
    assign vid.r_out           = rgb_q[7:5];
    assign vid.g_out           = rgb_q[4:2];
    assign vid.b_out           = rgb_q[1:0];
    assign vid.nes_x_out       = h_cnt;
    assign vid.nes_y_out       = v_cnt;
    assign vid.nes_y_next_out  = v_last ? 10'd0 : v_cnt + 10'd1;
    assign vid.pix_pulse_out   = pix_pulse;
    assign vid.vblank_out      = (v_ext >= V_ACT_END);
    assign vid.frame_start_out = pix_pulse && h_last && v_last;
endmodule

// File: tb/tb_nes_video_timing_gen.sv
// Directed bench for nes_video_timing_gen on an 8x6 raster with PIX_DIV=4, both sync polarities.
module tb_nes_video_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nes_video_timing_gen_if vi();
    nes_video_timing_gen_if vp();

    nes_video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(4), .SYNC_POL(0)
    ) u_dut (.clk(clk), .rst(rst), .vid(vi));

    nes_video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(4), .SYNC_POL(1)
    ) u_dut_p (.clk(clk), .rst(rst), .vid(vp));

    typedef struct {
        int         n;
        logic [9:0] h, v, yn;
        logic       pix, hs, vs, vb, fs;
        logic [7:0] rgb;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ncnt   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(int n, int h, int v, int pix, int hs, int vs,
                                int rgb, int vb, int yn, int fs);
        vec_t e;
        e.n = n; e.h = 10'(h); e.v = 10'(v); e.pix = 1'(pix); e.hs = 1'(hs);
        e.vs = 1'(vs); e.rgb = 8'(rgb); e.vb = 1'(vb); e.yn = 10'(yn); e.fs = 1'(fs);
        return e;
    endfunction

    function automatic int rgb_of(input logic [2:0] r, input logic [2:0] g, input logic [1:0] b);
        return int'({r, g, b});
    endfunction

    // Expected RGB332 for anchors and reserved entries; -1 means not checked.
    function automatic int exp_lut(input int idx);
        if (idx % 16 >= 13) return 0;
        case (idx)
            8'h00:        return 8'h6D;
            8'h02:        return 8'h02;
            8'h16:        return 8'hC4;
            8'h1A:        return 8'h14;
            8'h20, 8'h30: return 8'hFF;
            default:      return -1;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ncnt = 0;
    endtask

    task automatic step_to(input int n);
        while (ncnt < n) begin
            @(negedge clk);
            ncnt++;
        end
    endtask

    initial begin
        int lo_h, lo_v, vb_cnt, fs_cnt, pix_cnt, t;
        vi.en = 1'b1; vi.sys_palette_idx_in = 6'h16;
        vp.en = 1'b1; vp.sys_palette_idx_in = 6'h00;
`ifdef NES_VIDEO_TEST_PATTERN_EN
        vi.test_pattern_in = 1'b0;
        vp.test_pattern_in = 1'b0;
`endif
        //              n    h  v pix hs vs rgb   vb yn fs
        vecs.push_back(mk(1,   0, 0, 0, 1, 1, 8'h00, 0, 1, 0));
        vecs.push_back(mk(3,   0, 0, 0, 1, 1, 8'h00, 0, 1, 0));
        vecs.push_back(mk(4,   0, 0, 1, 1, 1, 8'h00, 0, 1, 0));
        vecs.push_back(mk(5,   1, 0, 0, 1, 1, 8'hC4, 0, 1, 0));
        vecs.push_back(mk(8,   1, 0, 1, 1, 1, 8'hC4, 0, 1, 0));
        vecs.push_back(mk(17,  4, 0, 0, 1, 1, 8'hC4, 0, 1, 0));
        vecs.push_back(mk(21,  5, 0, 0, 1, 1, 8'h00, 0, 1, 0));
        vecs.push_back(mk(25,  6, 0, 0, 0, 1, 8'h00, 0, 1, 0));
        vecs.push_back(mk(29,  7, 0, 0, 0, 1, 8'h00, 0, 1, 0));
        vecs.push_back(mk(33,  0, 1, 0, 1, 1, 8'h00, 0, 2, 0));
        vecs.push_back(mk(37,  1, 1, 0, 1, 1, 8'hC4, 0, 2, 0));
        vecs.push_back(mk(97,  0, 3, 0, 1, 1, 8'h00, 1, 4, 0));
        vecs.push_back(mk(101, 1, 3, 0, 1, 1, 8'h00, 1, 4, 0));
        vecs.push_back(mk(129, 0, 4, 0, 1, 1, 8'h00, 1, 5, 0));
        vecs.push_back(mk(133, 1, 4, 0, 1, 0, 8'h00, 1, 5, 0));
        vecs.push_back(mk(161, 0, 5, 0, 1, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(165, 1, 5, 0, 1, 1, 8'h00, 1, 0, 0));
        vecs.push_back(mk(192, 7, 5, 1, 0, 1, 8'h00, 1, 0, 1));
        vecs.push_back(mk(193, 0, 0, 0, 1, 1, 8'h00, 0, 1, 0));
        vecs.push_back(mk(197, 1, 0, 0, 1, 1, 8'hC4, 0, 1, 0));
        vecs.push_back(mk(384, 7, 5, 1, 0, 1, 8'h00, 1, 0, 1));

        do_reset();
        foreach (vecs[i]) begin
            step_to(vecs[i].n);
            chk($sformatf("n%0d.h", vecs[i].n),   int'(vi.nes_x_out), int'(vecs[i].h));
            chk($sformatf("n%0d.v", vecs[i].n),   int'(vi.nes_y_out), int'(vecs[i].v));
            chk($sformatf("n%0d.pix", vecs[i].n), int'(vi.pix_pulse_out), int'(vecs[i].pix));
            chk($sformatf("n%0d.hs", vecs[i].n),  int'(vi.hsync), int'(vecs[i].hs));
            chk($sformatf("n%0d.vs", vecs[i].n),  int'(vi.vsync), int'(vecs[i].vs));
            chk($sformatf("n%0d.rgb", vecs[i].n), rgb_of(vi.r_out, vi.g_out, vi.b_out), int'(vecs[i].rgb));
            chk($sformatf("n%0d.vb", vecs[i].n),  int'(vi.vblank_out), int'(vecs[i].vb));
            chk($sformatf("n%0d.yn", vecs[i].n),  int'(vi.nes_y_next_out), int'(vecs[i].yn));
            chk($sformatf("n%0d.fs", vecs[i].n),  int'(vi.frame_start_out), int'(vecs[i].fs));
            chk($sformatf("n%0d.hs_pol1", vecs[i].n), int'(vp.hsync), int'(!vecs[i].hs));
            chk($sformatf("n%0d.vs_pol1", vecs[i].n), int'(vp.vsync), int'(!vecs[i].vs));
        end

        // One full frame starting at raster (0,0)
        lo_h = 0; lo_v = 0; vb_cnt = 0; fs_cnt = 0; pix_cnt = 0;
        for (int k = 0; k < 192; k++) begin
            step_to(ncnt + 1);
            if (k < 32 && vi.hsync == 1'b0) lo_h++;
            if (k < 32 && vi.pix_pulse_out) pix_cnt++;
            if (vi.vsync == 1'b0) lo_v++;
            if (vi.vblank_out) vb_cnt++;
            if (vi.frame_start_out) fs_cnt++;
        end
        chk("line_hsync_low_clks", lo_h, 8);
        chk("line_pix_pulses", pix_cnt, 8);
        chk("frame_vsync_low_clks", lo_v, 32);
        chk("frame_vblank_clks", vb_cnt, 96);
        chk("frame_start_count", fs_cnt, 1);

        // Enable freeze mid-line at h=2
        do_reset();
        step_to(9);
        chk("en.pre_h", int'(vi.nes_x_out), 2);
        vi.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step_to(ncnt + 1);
            chk($sformatf("en.frz%0d.h", k), int'(vi.nes_x_out), 2);
            chk($sformatf("en.frz%0d.pix", k), int'(vi.pix_pulse_out), 0);
            chk($sformatf("en.frz%0d.rgb", k), rgb_of(vi.r_out, vi.g_out, vi.b_out), 8'hC4);
        end
        vi.en = 1'b1;
        step_to(ncnt + 2);
        chk("en.res2.pix", int'(vi.pix_pulse_out), 0);
        step_to(ncnt + 1);
        chk("en.res3.pix", int'(vi.pix_pulse_out), 1);
        chk("en.res3.h", int'(vi.nes_x_out), 2);
        step_to(ncnt + 1);
        chk("en.res4.h", int'(vi.nes_x_out), 3);
        chk("en.res4.rgb", rgb_of(vi.r_out, vi.g_out, vi.b_out), 8'hC4);

        // Reset asserted mid-frame at h=6, v=4
        do_reset();
        step_to(154);
        chk("mrst.pre_h", int'(vi.nes_x_out), 6);
        chk("mrst.pre_v", int'(vi.nes_y_out), 4);
        chk("mrst.pre_vs", int'(vi.vsync), 0);
        chk("mrst.pre_hs", int'(vi.hsync), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst.h", int'(vi.nes_x_out), 0);
        chk("mrst.v", int'(vi.nes_y_out), 0);
        chk("mrst.hs", int'(vi.hsync), 1);
        chk("mrst.vs", int'(vi.vsync), 1);
        chk("mrst.rgb", rgb_of(vi.r_out, vi.g_out, vi.b_out), 0);
        chk("mrst.yn", int'(vi.nes_y_next_out), 1);
        chk("mrst.vb", int'(vi.vblank_out), 0);
        chk("mrst.fs", int'(vi.frame_start_out), 0);
        chk("mrst.hs_pol1", int'(vp.hsync), 0);
        chk("mrst.vs_pol1", int'(vp.vsync), 0);
        ncnt = 1;
        for (int k = 2; k <= 5; k++) begin
            step_to(k);
            chk($sformatf("mrst.rec%0d.pix", k), int'(vi.pix_pulse_out), (k == 4) ? 1 : 0);
        end

        // Palette sweep on the active-high-sync instance
        for (int i = 0; i < 64; i++) begin
            t = 0;
            while (!(vp.pix_pulse_out && vp.nes_x_out < 10'd4 && vp.nes_y_out < 10'd3) && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (t >= 400) begin
                chk("sweep_timeout", 0, 1);
                break;
            end
            vp.sys_palette_idx_in = 6'(i);
            @(negedge clk);
            if (exp_lut(i) >= 0)
                chk($sformatf("lut_%02h", i), rgb_of(vp.r_out, vp.g_out, vp.b_out), exp_lut(i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
